// File: rtl/multiplier_arbiter_if.sv
// Bundle between two requesters, the arbiter and a shared sequential multiplier.
//   slave  : arbiter view (requests/operands/mul_done/mul_product in; acks, grants, result, multiplier drive out)
//   master : environment view (requesters and multiplier), directions mirrored
interface multiplier_arbiter_if #(
    parameter int unsigned WIDTH = 4
);
    logic                 req0;
    logic                 req1;
    logic [WIDTH-1:0]     a0;
    logic [WIDTH-1:0]     b0;
    logic [WIDTH-1:0]     a1;
    logic [WIDTH-1:0]     b1;
    logic                 ack0;
    logic                 ack1;
    logic                 err;
    logic [2*WIDTH-1:0]   result;
    logic                 grant0;
    logic                 grant1;
    logic                 busy;
    logic                 mul_start;
    logic [WIDTH-1:0]     mul_mcand;
    logic [WIDTH-1:0]     mul_mplier;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;

    modport slave (
        input  req0, req1, a0, b0, a1, b1, mul_done, mul_product,
        output ack0, ack1, err, result, grant0, grant1, busy,
               mul_start, mul_mcand, mul_mplier
    );

    modport master (
        output req0, req1, a0, b0, a1, b1, mul_done, mul_product,
        input  ack0, ack1, err, result, grant0, grant1, busy,
               mul_start, mul_mcand, mul_mplier
    );
endinterface

// File: rtl/multiplier_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier between two requesters.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : multiplier_arbiter_if.slave (requests, operands, acks, grants, result/err,
//         busy, multiplier start/operands, multiplier done/product)
// A granted transaction runs IDLE -> LAUNCH -> WAIT -> RESP; WAIT gives up after
// TIMEOUT cycles and returns err=1 with a zero result.
module multiplier_arbiter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned TIMEOUT = 2 * WIDTH + 8
) (
    input  logic                    clk,
    input  logic                    rst,
    multiplier_arbiter_if.slave     bus
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state;
    logic              last_served;
    logic [WIDTH-1:0]  mcand_q;
    logic [WIDTH-1:0]  mplier_q;
    logic [CW-1:0]     count;
    logic [PW-1:0]     result_q;
    logic              ack0_q;
    logic              ack1_q;
    logic              err_q;
    logic              grant0_q;
    logic              grant1_q;
    logic              busy_q;
    logic              start_q;

    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    logic pick1_c;
    assign pick1_c = bus.req1 & (~bus.req0 | ~last_served);

    logic [CW-1:0] count_inc_c;
    assign count_inc_c = count + CW'(1);

    // Transaction sequencer; every output is a register set on the transition into its state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last_served <= 1'b1;
            mcand_q     <= '0;
            mplier_q    <= '0;
            count       <= '0;
            result_q    <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            err_q       <= 1'b0;
            grant0_q    <= 1'b0;
            grant1_q    <= 1'b0;
            busy_q      <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        state       <= LAUNCH;
                        busy_q      <= 1'b1;
                        start_q     <= 1'b1;
                        grant0_q    <= ~pick1_c;
                        grant1_q    <= pick1_c;
                        last_served <= pick1_c;
                        mcand_q     <= pick1_c ? bus.a1 : bus.a0;
                        mplier_q    <= pick1_c ? bus.b1 : bus.b0;
                    end
                end
                LAUNCH: begin
                    state   <= WAIT;
                    start_q <= 1'b0;
                    count   <= '0;
                end
                WAIT: begin
                    // A done in the final allowed cycle still counts as success.
                    if (bus.mul_done) begin
                        state    <= RESP;
                        result_q <= bus.mul_product;
                        err_q    <= 1'b0;
                        ack0_q   <= grant0_q;
                        ack1_q   <= grant1_q;
                    end else if (count_inc_c == CW'(TIMEOUT)) begin
                        state    <= RESP;
                        count    <= count_inc_c;
                        result_q <= '0;
                        err_q    <= 1'b1;
                        ack0_q   <= grant0_q;
                        ack1_q   <= grant1_q;
                    end else begin
                        count <= count_inc_c;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    ack0_q   <= 1'b0;
                    ack1_q   <= 1'b0;
                    err_q    <= 1'b0;
                    grant0_q <= 1'b0;
                    grant1_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack0       = ack0_q;
    assign bus.ack1       = ack1_q;
    assign bus.err        = err_q;
    assign bus.result     = result_q;
    assign bus.grant0     = grant0_q;
    assign bus.grant1     = grant1_q;
    assign bus.busy       = busy_q;
    assign bus.mul_start  = start_q;
    assign bus.mul_mcand  = mcand_q;
    assign bus.mul_mplier = mplier_q;
endmodule
